fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_if.sv | 31 +++
 rtl/fifo_ptr.sv | 40 ++++
 rtl/fifo_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fifo_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO controller slice.
//   FIFO_DATA_WIDTH / FIFO_ADDR_WIDTH : default payload and RAM address widths
//   fifo_state_e                     : occupancy state (EMPTY / PARTIAL / FULL)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_if.sv
// ---------------------------------------------------------------------------
// fifo_if
// Producer/consumer handshake bundle for the FIFO controller.
//   wr_valid / wr_ready / wr_data : write side, push when valid && ready
//   rd_valid / rd_ready / rd_data : read side, pop when valid && ready
// Modports:
//   master : the user of the FIFO (drives wr_valid, wr_data, rd_ready)
//   slave  : the FIFO controller (drives wr_ready, rd_valid, rd_data)
// ---------------------------------------------------------------------------
interface fifo_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) ();

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// Wrapping FIFO pointer. The low bits address the RAM and the extra MSB is a
// wrap flag, so equal low bits can be told apart as empty or full.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, pointer returns to 0
//   en    : advance the pointer by one (modulo 2^PTR_WIDTH)
//   ptr   : current registered pointer value
// ---------------------------------------------------------------------------
module fifo_ptr import fifo_pkg::*; #(
  parameter int PTR_WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [PTR_WIDTH-1:0] ptr
);

  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  // Natural overflow of the adder gives the modulo-2^PTR_WIDTH wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = ptr_q + PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Control logic for a first-word-fall-through FIFO built around an external
// dual-port RAM (one write port, one asynchronous-read port).
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : fifo_if.slave handshake (wr_* push side, rd_* pop side)
//   count        : number of stored entries, registered
//   almost_full  : registered, count >= AF_LEVEL
//   almost_empty : registered, count <= AE_LEVEL
//   overflow     : sticky, push attempted while full
//   underflow    : sticky, pop attempted while empty
//   clr_err      : synchronous clear of overflow/underflow
//   ram_*_0      : RAM write port (address, chip enable, write enable, data)
//   ram_*_1      : RAM read port (address, chip enable, write enable, data in)
// ---------------------------------------------------------------------------
module fifo_ctrl import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_if.slave                 bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic                  ram_ce_0,
  output logic                  ram_wr_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
  output logic                  ram_ce_1,
  output logic                  ram_wr_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;
  fifo_state_e   state_q;
  fifo_state_e   state_d;
  logic          almost_full_q;
  logic          almost_full_d;
  logic          almost_empty_q;
  logic          almost_empty_d;
  logic          overflow_q;
  logic          overflow_d;
  logic          underflow_q;
  logic          underflow_d;

  // Empty/full come straight from the registered pointers: equal pointers mean
  // empty, equal addresses with opposite wrap flags mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign bus.wr_ready = !full;
  assign bus.rd_valid = !empty;

  // Gating with rst_n keeps the RAM write enable low for the whole time reset
  // is held, even if the producer keeps wr_valid high.
  assign push = rst_n && bus.wr_valid && !full;
  assign pop  = rst_n && bus.rd_ready && !empty;

  fifo_ptr #(.PTR_WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PTR_WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop),
    .ptr   (rd_ptr)
  );

  assign ram_addr_0 = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_ce_0   = push;
  assign ram_wr_0   = push;
  assign ram_data_0 = bus.wr_data;

  // The read port is always enabled at the head address, so the oldest entry
  // falls through to rd_data without a request.
  assign ram_addr_1  = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_ce_1    = 1'b1;
  assign ram_wr_1    = 1'b0;
  assign bus.rd_data = ram_data_1;

  // Next-state computation. The occupancy state and both threshold flags are
  // derived from the next count so they line up with count after the edge.
  always_comb begin
    count_d        = count_q;
    state_d        = state_q;
    almost_full_d  = almost_full_q;
    almost_empty_d = almost_empty_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    if (push != pop) begin
      if (count_d == '0) begin
        state_d = ST_EMPTY;
      end else if (count_d == DEPTH_C) begin
        state_d = ST_FULL;
      end else begin
        state_d = ST_PARTIAL;
      end
    end

    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);

    // A new error in the same cycle as clr_err wins over the clear.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_valid && full) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_ready && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      state_q        <= ST_EMPTY;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      count_q        <= count_d;
      state_q        <= state_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // The occupancy state register must always agree with the pointer compare.
  state_matches_ptrs_a: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == ST_EMPTY) == empty) && ((state_q == ST_FULL) == full));

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
// Self-checking bench for fifo_ctrl (DATA_WIDTH=8, ADDR_WIDTH=2, AF=3, AE=1).
// A behavioural RAM is attached to the two RAM ports; a queue-based model of
// the FIFO contents and sticky flags is compared with the DUT on every
// falling edge, and directed scenarios pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk;
  logic          rst_n;
  logic          clr_err;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
  logic [AW-1:0] ram_addr_0;
  logic          ram_ce_0;
  logic          ram_wr_0;
  logic [DW-1:0] ram_data_0;
  logic [AW-1:0] ram_addr_1;
  logic          ram_ce_1;
  logic          ram_wr_1;
  logic [DW-1:0] ram_data_1;

  logic [DW-1:0] mem [DEPTH];

  int            checks;
  int            errors;

  // Model state: FIFO contents in order, totals of accepted pushes/pops since
  // reset (their value modulo DEPTH is where the next write/read must go),
  // and the two sticky error flags.
  logic [DW-1:0] model_q [$];
  int unsigned   wr_cnt;
  int unsigned   rd_cnt;
  logic          m_ov;
  logic          m_un;
  logic          cmp_en;

  fifo_state_e   exp_state;
  int            sz;
  logic [DW-1:0] fill_vals [4];

  fifo_if #(.DATA_WIDTH(DW)) bus ();

  fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err),
    .ram_addr_0   (ram_addr_0),
    .ram_ce_0     (ram_ce_0),
    .ram_wr_0     (ram_wr_0),
    .ram_data_0   (ram_data_0),
    .ram_addr_1   (ram_addr_1),
    .ram_ce_1     (ram_ce_1),
    .ram_wr_1     (ram_wr_1),
    .ram_data_1   (ram_data_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (ram_ce_0 && ram_wr_0) begin
      mem[ram_addr_0] <= ram_data_0;
    end
  end
  assign ram_data_1 = mem[ram_addr_1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model with the
  // handshake rules, and return just after the following falling edge.
  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd,
                               input logic rr, input logic ce);
    logic do_push;
    logic do_pop;
    logic set_ov;
    logic set_un;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    clr_err      = ce;
    do_push = wv && (model_q.size() < DEPTH);
    do_pop  = rr && (model_q.size() > 0);
    set_ov  = wv && (model_q.size() == DEPTH);
    set_un  = rr && (model_q.size() == 0);
    @(posedge clk);
    if (rst_n) begin
      if (do_pop) begin
        void'(model_q.pop_front());
        rd_cnt++;
      end
      if (do_push) begin
        model_q.push_back(wd);
        wr_cnt++;
      end
      if (set_ov) m_ov = 1'b1;
      else if (ce) m_ov = 1'b0;
      if (set_un) m_un = 1'b1;
      else if (ce) m_un = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    model_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      sz = model_q.size();
      if (sz == 0) exp_state = ST_EMPTY;
      else if (sz == DEPTH) exp_state = ST_FULL;
      else exp_state = ST_PARTIAL;
      checkOutput("wr_ready", 32'(bus.wr_ready), 32'(sz < DEPTH));
      checkOutput("rd_valid", 32'(bus.rd_valid), 32'(sz > 0));
      checkOutput("count", 32'(count), 32'(sz));
      checkOutput("almost_full", 32'(almost_full), 32'(sz >= AF));
      checkOutput("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      checkOutput("overflow", 32'(overflow), 32'(m_ov));
      checkOutput("underflow", 32'(underflow), 32'(m_un));
      checkOutput("state", 32'(dut.state_q), 32'(exp_state));
      checkOutput("ram_ce_0", 32'(ram_ce_0), 32'(rst_n && bus.wr_valid && (sz < DEPTH)));
      checkOutput("ram_wr_0", 32'(ram_wr_0), 32'(rst_n && bus.wr_valid && (sz < DEPTH)));
      checkOutput("ram_addr_0", 32'(ram_addr_0), wr_cnt % DEPTH);
      checkOutput("ram_data_0", 32'(ram_data_0), 32'(bus.wr_data));
      checkOutput("ram_addr_1", 32'(ram_addr_1), rd_cnt % DEPTH);
      checkOutput("ram_ce_1", 32'(ram_ce_1), 32'd1);
      checkOutput("ram_wr_1", 32'(ram_wr_1), 32'd0);
      if (sz > 0) begin
        checkOutput("rd_data", 32'(bus.rd_data), 32'(model_q[0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cmp_en    = 1'b0;
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    bus.rd_ready = 1'b0;
    clr_err      = 1'b0;
    applyReset();
    repeat (2) @(negedge clk);
    #1;

    // Reset values, with wr_valid held high to show the RAM is not written.
    checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
    checkOutput("rst_ram_ce_0", 32'(ram_ce_0), 32'd0);
    bus.wr_valid = 1'b0;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    #1;

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_vals[i], 1'b0, 1'b0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("full_almost_full", 32'(almost_full), 32'd1);
    checkOutput("full_state", 32'(dut.state_q), 32'(ST_FULL));
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_rd_data", 32'(bus.rd_data), 32'(fill_vals[i]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drained_count", 32'(count), 32'd0);

    // Push while full with a same-cycle pop: push refused, overflow set.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_vals[i], 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'd3);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_head", 32'(bus.rd_data), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 1; i < 4; i++) begin
      checkOutput("ovf_drain_data", 32'(bus.rd_data), 32'(fill_vals[i]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Pop while empty: underflow set, nothing moves.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf_flag", 32'(underflow), 32'd1);
    checkOutput("unf_count", 32'(count), 32'd0);
    checkOutput("unf_wr_addr", 32'(ram_addr_0), 32'd0);
    checkOutput("unf_rd_addr", 32'(ram_addr_1), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("unf_cleared", 32'(underflow), 32'd0);

    // Two entries deep, simultaneous push+pop for 10 cycles.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stream_rd_data", 32'(bus.rd_data),
                  (i == 0) ? 32'h01 : (i == 1) ? 32'h02 : 32'(8'h10 + i - 2));
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
      checkOutput("stream_count", 32'(count), 32'd2);
    end
    checkOutput("stream_head", 32'(bus.rd_data), 32'h18);
    checkOutput("stream_wr_addr", 32'(ram_addr_0), 32'd0);
    checkOutput("stream_rd_addr", 32'(ram_addr_1), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    applyReset();
    #1;
    checkOutput("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("mid_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("mid_rst_almost_full", 32'(almost_full), 32'd0);
    checkOutput("mid_rst_ram_ce_0", 32'(ram_ce_0), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_wr_addr", 32'(ram_addr_0), 32'd0);
    checkOutput("post_rst_ram_ce_0", 32'(ram_ce_0), 32'd1);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("post_rst_rd_data", 32'(bus.rd_data), 32'hA5);
    checkOutput("post_rst_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic in phases biased toward filling, draining, balanced.
    for (int i = 0; i < 3000; i++) begin
      int  mode;
      int  wr_pct;
      int  rd_pct;
      logic wv;
      logic rr;
      logic ce;
      mode   = (i / 250) % 3;
      wr_pct = (mode == 0) ? 80 : (mode == 1) ? 30 : 55;
      rd_pct = (mode == 0) ? 30 : (mode == 1) ? 80 : 55;
      wv = ($urandom_range(0, 99) < 32'(wr_pct));
      rr = ($urandom_range(0, 99) < 32'(rd_pct));
      ce = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) begin
        applyReset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
      applyStimulus(wv, 8'($urandom), rr, ce);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
